regfile_wb_arbiter: RTL and testbench

//  Sole owner of the regfile write port (wrd/addr_d/d). Merges three writeback sources: in-order

---
 rtl/regfile_wb_arbiter.sv | 108 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - regfile writeback arbiter with pending-write scoreboard
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_valid,
  input  logic [4:0]        p0_rd,
  input  logic [DATA_W-1:0] p0_data,
  input  logic              p1_valid,
  input  logic [4:0]        p1_rd,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p1_ready,
  input  logic              p2_valid,
  input  logic [4:0]        p2_rd,
  input  logic [DATA_W-1:0] p2_data,
  output logic              p2_ready,
  input  logic              iss_valid,
  input  logic [4:0]        iss_rd,
  output logic              iss_stall,
  input  logic [4:0]        chk_a,
  input  logic [4:0]        chk_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              stall_pipe,
  output logic              rf_wrd,
  output logic [4:0]        rf_addr_d,
  output logic [DATA_W-1:0] rf_d,
  output logic              err
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [31:0]       pending;
  logic              rr;
  logic [CW-1:0]     wait_cnt;
  logic              g0, g1, g2, any_grant;
  logic [4:0]        w_rd;
  logic [DATA_W-1:0] w_data;
  logic [31:0]       set_mask, clr_mask;

  // Grant selection: p0 always wins, otherwise rr breaks p1/p2 ties
  always_comb begin
    g0 = p0_valid;
    g1 = 1'b0;
    g2 = 1'b0;
    if (!p0_valid) begin
      g1 = p1_valid & (!p2_valid | !rr);
      g2 = p2_valid & (!p1_valid |  rr);
    end
    any_grant = g0 | g1 | g2;
    w_rd   = 5'd0;
    w_data = '0;
    if (g0) begin
      w_rd   = p0_rd;
      w_data = p0_data;
    end else if (g1) begin
      w_rd   = p1_rd;
      w_data = p1_data;
    end else if (g2) begin
      w_rd   = p2_rd;
      w_data = p2_data;
    end
  end

  // Handshakes, hazard lookups and scoreboard update masks
  always_comb begin
    p1_ready   = g1 & !reset;
    p2_ready   = g2 & !reset;
    stall_pipe = (wait_cnt == LIMIT);
    iss_stall  = iss_valid & (iss_rd != 5'd0) & pending[iss_rd];
    hazard_a   = (chk_a != 5'd0) & (pending[chk_a] | (rf_wrd & (rf_addr_d == chk_a)));
    hazard_b   = (chk_b != 5'd0) & (pending[chk_b] | (rf_wrd & (rf_addr_d == chk_b)));
    set_mask   = '0;
    clr_mask   = '0;
    if (iss_valid && !iss_stall && iss_rd != 5'd0) set_mask = 32'd1 << iss_rd;
    if (g1)      clr_mask = 32'd1 << p1_rd;
    else if (g2) clr_mask = 32'd1 << p2_rd;
  end

  // Registered regfile write port, scoreboard, round-robin and starvation state
  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= '0;
      rr        <= 1'b0;
      wait_cnt  <= '0;
      rf_wrd    <= 1'b0;
      rf_addr_d <= 5'd0;
      rf_d      <= '0;
      err       <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      if (g1) rr <= 1'b1;
      else if (g2) rr <= 1'b0;
      if (g1 || g2 || !(p1_valid || p2_valid)) wait_cnt <= '0;
      else if (p0_valid && wait_cnt != LIMIT) wait_cnt <= wait_cnt + CW'(1);
      rf_wrd <= any_grant & (w_rd != 5'd0);
      if (any_grant) begin
        rf_addr_d <= w_rd;
        rf_d      <= w_data;
      end
      if (p0_valid && stall_pipe) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_valid, p1_valid, p2_valid, iss_valid;
  logic [4:0]  p0_rd, p1_rd, p2_rd, iss_rd, chk_a, chk_b;
  logic [31:0] p0_data, p1_data, p2_data;
  logic        p1_ready, p2_ready, iss_stall, hazard_a, hazard_b, stall_pipe;
  logic        rf_wrd, err;
  logic [4:0]  rf_addr_d;
  logic [31:0] rf_d;

  regfile_wb_arbiter #(.DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_rd(p0_rd), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_rd(p1_rd), .p1_data(p1_data), .p1_ready(p1_ready),
    .p2_valid(p2_valid), .p2_rd(p2_rd), .p2_data(p2_data), .p2_ready(p2_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_stall(iss_stall),
    .chk_a(chk_a), .chk_b(chk_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .stall_pipe(stall_pipe), .rf_wrd(rf_wrd), .rf_addr_d(rf_addr_d), .rf_d(rf_d),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [4:0]  rd;
    bit [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Reference model: which registers await a long-latency write, who is preferred,
  // how long p1/p2 have been starved, and what the regfile saw last cycle.
  bit       pend_m[32];
  bit       pref2;
  int       starve;
  bit       err_m;
  bit       prev_wr;
  bit [4:0] prev_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit hz(input bit [4:0] r);
    return (r != 0) && (pend_m[r] || (prev_wr && prev_rd == r));
  endfunction

  // Monitor: every regfile write the DUT presents must be the oldest expected one
  always @(negedge clk) begin
    if (!reset && rf_wrd) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write", rf_addr_d, rf_d);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", rf_addr_d, w.rd);
        chk("wr_data", rf_d, w.d);
      end
    end
  end

  task automatic cycle();
    int g;
    bit drop1, drop2;
    drop1 = 0;
    drop2 = 0;
    @(negedge clk);
    if (reset) begin
      chk("p1_ready_rst", p1_ready, 0);
      chk("p2_ready_rst", p2_ready, 0);
      foreach (pend_m[i]) pend_m[i] = 0;
      exp_q.delete();
      pref2   = 0;
      starve  = 0;
      err_m   = 0;
      prev_wr = 0;
      prev_rd = 0;
    end else begin
      if (p0_valid)                g = 3;
      else if (p1_valid && p2_valid) g = pref2 ? 2 : 1;
      else if (p1_valid)           g = 1;
      else if (p2_valid)           g = 2;
      else                         g = 0;
      chk("p1_ready", p1_ready, g == 1);
      chk("p2_ready", p2_ready, g == 2);
      chk("iss_stall", iss_stall, iss_valid && iss_rd != 0 && pend_m[iss_rd]);
      chk("hazard_a", hazard_a, hz(chk_a));
      chk("hazard_b", hazard_b, hz(chk_b));
      chk("stall_pipe", stall_pipe, starve == LIMIT);
      chk("err", err, err_m);
      chk("rf_wrd", rf_wrd, prev_wr);
      if (p0_valid && starve == LIMIT) err_m = 1;
      if (g == 1 || g == 2 || !(p1_valid || p2_valid)) starve = 0;
      else if (p0_valid && starve < LIMIT) starve++;
      prev_wr = 0;
      if (g != 0) begin
        wr_t w;
        w.rd = (g == 3) ? p0_rd : (g == 1) ? p1_rd : p2_rd;
        w.d  = (g == 3) ? p0_data : (g == 1) ? p1_data : p2_data;
        if (g == 1 || g == 2) begin
          pend_m[w.rd] = 0;
          pref2 = (g == 1);
        end
        if (w.rd != 0) begin
          exp_q.push_back(w);
          prev_wr = 1;
          prev_rd = w.rd;
        end
      end
      if (iss_valid && iss_rd != 0 && !(pend_m[iss_rd] && g != 1 && g != 2) &&
          !(iss_stall === 1'b1))
        pend_m[iss_rd] = 1;
      drop1 = (g == 1);
      drop2 = (g == 2);
    end
    @(posedge clk);
    #1;
    if (drop1) p1_valid = 0;
    if (drop2) p2_valid = 0;
  endtask

  task automatic idle();
    p0_valid  = 0;
    iss_valid = 0;
    chk_a     = 0;
    chk_b     = 0;
  endtask

  initial begin
    reset = 1;
    p0_valid = 0; p1_valid = 1; p2_valid = 1; iss_valid = 0;
    p0_rd = 0; p1_rd = 3; p2_rd = 4; iss_rd = 0; chk_a = 0; chk_b = 0;
    p0_data = 0; p1_data = 32'h11; p2_data = 32'h22;
    #1;
    repeat (3) cycle();
    reset = 0;
    p1_valid = 0;
    p2_valid = 0;
    cycle();
    chk("rf_addr_d_rst", rf_addr_d, 0);
    chk("rf_d_rst", rf_d, 0);
    cycle();

    // pipeline write to x5
    p0_valid = 1; p0_rd = 5; p0_data = 32'hDEADBEEF;
    cycle();
    p0_valid = 0;
    cycle();
    cycle();

    // WAW on x7, RAW hazard on x7 until one cycle after the mul/div write
    iss_valid = 1; iss_rd = 7; chk_a = 7;
    cycle();
    cycle();
    iss_valid = 0;
    cycle();
    p1_valid = 1; p1_rd = 7; p1_data = 32'h7777;
    repeat (4) cycle();
    idle();

    // p1/p2 contention alternates; rd=0 completes without a write
    for (int k = 0; k < 2; k++) begin
      p1_valid = 1; p1_rd = (k == 0) ? 5'd0 : 5'd10; p1_data = 32'hA000 + k;
      p2_valid = 1; p2_rd = 5'd11 + 5'(k);          p2_data = 32'hB000 + k;
      repeat (3) cycle();
    end

    // starvation: p0 held with p1 waiting, then p0 drops
    p1_valid = 1; p1_rd = 12; p1_data = 32'hC0C0;
    p0_valid = 1; p0_rd = 1; p0_data = 32'h1;
    repeat (LIMIT) cycle();
    p0_valid = 0;
    repeat (2) cycle();

    // protocol violation: p0 held through the stall
    p1_valid = 1; p1_rd = 13; p1_data = 32'hE1;
    p0_valid = 1;
    repeat (LIMIT + 2) cycle();
    p0_valid = 0;
    repeat (2) cycle();

    // reset with a pending bit and an in-flight write
    iss_valid = 1; iss_rd = 9;
    cycle();
    iss_valid = 0; chk_a = 9;
    cycle();
    p0_valid = 1; p0_rd = 9; p0_data = 32'h99;
    reset = 1;
    cycle();
    p0_valid = 0;
    cycle();
    reset = 0;
    repeat (2) cycle();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      p0_valid = (($urandom % 3) == 0) && (starve != LIMIT);
      p0_rd = 5'($urandom % 8); p0_data = $urandom;
      if (!p1_valid && ($urandom % 3) == 0) begin
        p1_valid = 1; p1_rd = 5'($urandom % 8); p1_data = $urandom;
      end
      if (!p2_valid && ($urandom % 3) == 0) begin
        p2_valid = 1; p2_rd = 5'($urandom % 8); p2_data = $urandom;
      end
      iss_valid = ($urandom % 3) == 0;
      iss_rd = 5'($urandom % 8);
      chk_a = 5'($urandom % 8);
      chk_b = 5'($urandom % 8);
      cycle();
    end

    idle();
    for (int n = 0; n < 10 && (p1_valid || p2_valid); n++) cycle();
    repeat (3) cycle();
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
